// File: rtl/dcache_load_responder_pkg.sv
// dcache_load_responder_pkg: widths, MAT encodings and queue entry layout shared with the load buffer
package dcache_load_responder_pkg;
    localparam int LB_PTR_W = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAT_W = 2;
    typedef enum logic [MAT_W-1:0] {MAT_SUC = 2'b00, MAT_CC = 2'b01} mat_e;
    localparam int ENT_ADDR_LSB = 0;
    localparam int ENT_PTR_LSB = ENT_ADDR_LSB + ADDR_W;
    localparam int ENT_MAT_LSB = ENT_PTR_LSB + LB_PTR_W;
    localparam int ENT_ISSUED = ENT_MAT_LSB + MAT_W;
    localparam int ENT_VALID = ENT_ISSUED + 1;
    localparam int ENT_W = ENT_VALID + 1;
endpackage

// File: rtl/dcache_load_responder_queue.sv
// dcache_load_queue: in-order request storage with alloc/issue/response pointers and flush discard counter
module dcache_load_queue
    import dcache_load_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW = 2
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                flush,
    input  logic                alloc,
    input  logic [MAT_W-1:0]    alloc_mat,
    input  logic [LB_PTR_W-1:0] alloc_lb_ptr,
    input  logic [ADDR_W-1:0]   alloc_addr,
    input  logic                issue,
    input  logic                pop,
    input  logic                mem_valid,
    output logic                full,
    output logic                has_issued,
    output logic                discard_zero,
    output logic                issue_pending,
    output logic [MAT_W-1:0]    issue_mat,
    output logic [ADDR_W-1:0]   issue_addr,
    output logic [LB_PTR_W-1:0] resp_lb_ptr
);
    localparam logic [PTRW:0] PTR_ONE = 1;
    localparam logic [PTRW+1:0] CNT_ONE = 1;
    logic [ENT_W-1:0] entries [DEPTH];
    logic [PTRW:0] alloc_ptr, issue_ptr, resp_ptr, outstanding;
    logic [PTRW+1:0] discard_cnt, discard_total;
    assign outstanding = issue_ptr - resp_ptr;
    assign discard_total = discard_cnt + {1'b0, outstanding};
    assign full = (alloc_ptr[PTRW] != resp_ptr[PTRW]) && (alloc_ptr[PTRW-1:0] == resp_ptr[PTRW-1:0]);
    assign has_issued = outstanding != '0;
    assign discard_zero = discard_cnt == '0;
    assign issue_pending = entries[issue_ptr[PTRW-1:0]][ENT_VALID] && !entries[issue_ptr[PTRW-1:0]][ENT_ISSUED];
    assign issue_mat = entries[issue_ptr[PTRW-1:0]][ENT_MAT_LSB +: MAT_W];
    assign issue_addr = entries[issue_ptr[PTRW-1:0]][ENT_ADDR_LSB +: ADDR_W];
    assign resp_lb_ptr = entries[resp_ptr[PTRW-1:0]][ENT_PTR_LSB +: LB_PTR_W];
    // entry storage: write on accept, mark issued on handshake, invalidate on response
    always_ff @(posedge Clk) begin
        if (Rest) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i][ENT_VALID] <= 1'b0;
        end else begin
            if (alloc) entries[alloc_ptr[PTRW-1:0]] <= {1'b1, 1'b0, alloc_mat, alloc_lb_ptr, alloc_addr};
            if (issue) entries[issue_ptr[PTRW-1:0]][ENT_ISSUED] <= 1'b1;
            if (pop) entries[resp_ptr[PTRW-1:0]][ENT_VALID] <= 1'b0;
        end
    end
    // circular pointers with wrap bit; flush rewinds everything to slot 0
    always_ff @(posedge Clk) begin
        if (Rest || flush) begin
            alloc_ptr <= '0;
            issue_ptr <= '0;
            resp_ptr <= '0;
        end else begin
            if (alloc) alloc_ptr <= alloc_ptr + PTR_ONE;
            if (issue) issue_ptr <= issue_ptr + PTR_ONE;
            if (pop) resp_ptr <= resp_ptr + PTR_ONE;
        end
    end
    // count memory returns still owed for flushed requests; a return in the flush cycle consumes one
    always_ff @(posedge Clk) begin
        if (Rest) discard_cnt <= '0;
        else if (flush) discard_cnt <= discard_total - ((mem_valid && discard_total != '0) ? CNT_ONE : '0);
        else if (mem_valid && !discard_zero) discard_cnt <= discard_cnt - CNT_ONE;
    end
endmodule

// File: rtl/dcache_load_responder.sv
// dcache_load_responder: accepts load-buffer requests, issues them to memory in order, returns tagged data
module dcache_load_responder
    import dcache_load_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW = 2
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                DcdFlash,
    input  logic                LbToDcdAble,
    input  logic [MAT_W-1:0]    LbToDcdAMat,
    input  logic [LB_PTR_W-1:0] LbToDcdAPtr,
    input  logic [ADDR_W-1:0]   LbToDcdAPhyAddr,
    output logic                DcdToLbSuccess,
    output logic                DcdToLbBackAble,
    output logic [LB_PTR_W-1:0] DcdToLbBackPtr,
    output logic [DATA_W-1:0]   DcdToLbBackDate,
    output logic                DcdRdReq,
    output logic [ADDR_W-1:0]   DcdRdAddr,
    output logic                DcdRdUncache,
    input  logic                MemRdReady,
    input  logic                MemRdValid,
    input  logic [DATA_W-1:0]   MemRdDate
);
    logic full, has_issued, discard_zero, issue_pending, pop;
    logic [MAT_W-1:0] issue_mat;
    logic [LB_PTR_W-1:0] resp_lb_ptr;
    logic [(1 << LB_PTR_W)-1:0] in_flight_mask;
    assign DcdToLbSuccess = LbToDcdAble && !full && !DcdFlash && !Rest && LbToDcdAPtr != '0 && !in_flight_mask[LbToDcdAPtr];
    assign DcdRdReq = issue_pending && !DcdFlash;
    assign DcdRdUncache = issue_mat != MAT_CC;
    assign pop = MemRdValid && !DcdFlash && discard_zero && has_issued;
    dcache_load_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) u_queue (
        .Clk(Clk),
        .Rest(Rest),
        .flush(DcdFlash),
        .alloc(DcdToLbSuccess),
        .alloc_mat(LbToDcdAMat),
        .alloc_lb_ptr(LbToDcdAPtr),
        .alloc_addr(LbToDcdAPhyAddr),
        .issue(DcdRdReq && MemRdReady),
        .pop(pop),
        .mem_valid(MemRdValid),
        .full(full),
        .has_issued(has_issued),
        .discard_zero(discard_zero),
        .issue_pending(issue_pending),
        .issue_mat(issue_mat),
        .issue_addr(DcdRdAddr),
        .resp_lb_ptr(resp_lb_ptr)
    );
    // one load-buffer pointer may have only one request in flight
    always_ff @(posedge Clk) begin
        if (Rest || DcdFlash) begin
            in_flight_mask <= '0;
        end else begin
            if (pop) in_flight_mask[resp_lb_ptr] <= 1'b0;
            if (DcdToLbSuccess) in_flight_mask[LbToDcdAPtr] <= 1'b1;
        end
    end
    // registered response: one-cycle pulse tagged with the original load-buffer pointer
    always_ff @(posedge Clk) begin
        if (Rest) begin
            DcdToLbBackAble <= 1'b0;
            DcdToLbBackPtr <= '0;
            DcdToLbBackDate <= '0;
        end else begin
            DcdToLbBackAble <= pop;
            if (pop) begin
                DcdToLbBackPtr <= resp_lb_ptr;
                DcdToLbBackDate <= MemRdDate;
            end
        end
    end
    a_no_orphan_return: assert property (@(posedge Clk) disable iff (Rest)
        (MemRdValid && !DcdFlash) |-> (!discard_zero || has_issued));
endmodule

// File: tb/tb_dcache_load_responder.sv
// tb_dcache_load_responder: directed stimulus with a response scoreboard for dcache_load_responder
module tb_dcache_load_responder;
    logic Clk = 1'b0;
    logic Rest, DcdFlash, LbToDcdAble, MemRdReady, MemRdValid;
    logic [1:0] LbToDcdAMat;
    logic [2:0] LbToDcdAPtr;
    logic [31:0] LbToDcdAPhyAddr, MemRdDate;
    logic DcdToLbSuccess, DcdToLbBackAble, DcdRdReq, DcdRdUncache;
    logic [2:0] DcdToLbBackPtr;
    logic [31:0] DcdToLbBackDate, DcdRdAddr;
    typedef struct {logic [2:0] ptr; logic [31:0] data; int due;} resp_t;
    resp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;

    dcache_load_responder dut (
        .Clk(Clk), .Rest(Rest), .DcdFlash(DcdFlash),
        .LbToDcdAble(LbToDcdAble), .LbToDcdAMat(LbToDcdAMat), .LbToDcdAPtr(LbToDcdAPtr),
        .LbToDcdAPhyAddr(LbToDcdAPhyAddr), .DcdToLbSuccess(DcdToLbSuccess),
        .DcdToLbBackAble(DcdToLbBackAble), .DcdToLbBackPtr(DcdToLbBackPtr),
        .DcdToLbBackDate(DcdToLbBackDate), .DcdRdReq(DcdRdReq), .DcdRdAddr(DcdRdAddr),
        .DcdRdUncache(DcdRdUncache), .MemRdReady(MemRdReady), .MemRdValid(MemRdValid),
        .MemRdDate(MemRdDate)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic [2:0] p, input logic [1:0] m, input logic [31:0] a);
        LbToDcdAble = 1'b1;
        LbToDcdAPtr = p;
        LbToDcdAMat = m;
        LbToDcdAPhyAddr = a;
    endtask

    task automatic ret(input logic [2:0] p, input logic [31:0] d);
        MemRdValid = 1'b1;
        MemRdDate = d;
        sb.push_back('{ptr: p, data: d, due: cyc_n + 1});
    endtask

    task automatic drop(input logic [31:0] d);
        MemRdValid = 1'b1;
        MemRdDate = d;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic unc);
        chk({tag, "_req"}, 32'(DcdRdReq), 1);
        chk({tag, "_addr"}, DcdRdAddr, a);
        chk({tag, "_unc"}, 32'(DcdRdUncache), 32'(unc));
    endtask

    // every response pulse must match the oldest expected return, one cycle after MemRdValid
    always @(negedge Clk) begin
        if (DcdToLbBackAble === 1'b1) begin : mon
            resp_t e;
            if (sb.size() == 0) begin
                chk("back_unexpected", 32'(DcdToLbBackPtr), 0);
            end else begin
                e = sb.pop_front();
                chk("back_ptr", 32'(DcdToLbBackPtr), 32'(e.ptr));
                chk("back_date", DcdToLbBackDate, e.data);
                chk("back_cycle", cyc_n, e.due);
            end
        end
    end

    initial begin
        Rest = 1'b1; DcdFlash = 1'b0; MemRdReady = 1'b0; MemRdValid = 1'b0; MemRdDate = '0;
        req(3'd1, 2'b01, 32'h0);
        #2 chk("rst_success_gate", 32'(DcdToLbSuccess), 0);
        cyc(2);
        Rest = 1'b0; LbToDcdAble = 1'b0;
        #1 chk("rst_back_able", 32'(DcdToLbBackAble), 0);
        chk("rst_back_ptr", 32'(DcdToLbBackPtr), 0);
        chk("rst_back_date", DcdToLbBackDate, 0);
        chk("rst_rdreq", 32'(DcdRdReq), 0);
        cyc();

        req(3'd3, 2'b01, 32'h1000_0040);
        #1 chk("basic_success", 32'(DcdToLbSuccess), 1);
        cyc(); LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        #1 chk_rd("basic", 32'h1000_0040, 1'b0);
        cyc(); MemRdReady = 1'b0;
        #1 chk("basic_rd_done", 32'(DcdRdReq), 0);
        cyc(); ret(3'd3, 32'hDEAD_BEEF);
        cyc(); MemRdValid = 1'b0;
        cyc(2);

        for (int i = 1; i <= 4; i++) begin
            req(i[2:0], 2'b01, 32'h100 + i * 4);
            #1 chk("full_accept", 32'(DcdToLbSuccess), 1);
            cyc();
        end
        req(3'd5, 2'b01, 32'h114);
        #1 chk("full_reject", 32'(DcdToLbSuccess), 0);
        MemRdReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1 chk_rd("full_issue", 32'h100 + i * 4, 1'b0);
            chk("full_hold", 32'(DcdToLbSuccess), 0);
            cyc();
        end
        MemRdReady = 1'b0;
        ret(3'd1, 32'hA000_0001);
        #1 chk("full_resp_cycle", 32'(DcdToLbSuccess), 0);
        cyc(); MemRdValid = 1'b0;
        #1 chk("full_freed", 32'(DcdToLbSuccess), 1);
        cyc(); LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        #1 chk_rd("full_issue5", 32'h114, 1'b0);
        cyc(); MemRdReady = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            ret(i[2:0], 32'hA000_0000 + i);
            cyc();
        end
        MemRdValid = 1'b0;
        cyc(2);

        req(3'd2, 2'b01, 32'h200);
        #1 chk("dup_first", 32'(DcdToLbSuccess), 1);
        cyc(); req(3'd2, 2'b01, 32'h204); MemRdReady = 1'b1;
        #1 chk("dup_outstanding", 32'(DcdToLbSuccess), 0);
        chk_rd("dup_issue", 32'h200, 1'b0);
        cyc(); MemRdReady = 1'b0;
        ret(3'd2, 32'h2222_0001);
        #1 chk("dup_resp_cycle", 32'(DcdToLbSuccess), 0);
        cyc(); MemRdValid = 1'b0;
        #1 chk("dup_after_back", 32'(DcdToLbSuccess), 1);
        cyc(); req(3'd0, 2'b01, 32'h300);
        #1 chk("ptr0_reject", 32'(DcdToLbSuccess), 0);
        cyc();
        #1 chk("ptr0_reject_again", 32'(DcdToLbSuccess), 0);
        LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        #1 chk_rd("dup_issue2", 32'h204, 1'b0);
        cyc(); MemRdReady = 1'b0;
        ret(3'd2, 32'h2222_0002);
        cyc(); MemRdValid = 1'b0;
        cyc(2);

        for (int i = 1; i <= 4; i++) begin
            req(i[2:0], 2'b01, 32'h400 + i * 4);
            #1 chk("fl_accept", 32'(DcdToLbSuccess), 1);
            cyc();
        end
        LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        cyc(3); MemRdReady = 1'b0;
        #1 chk("fl_pending_rdreq", 32'(DcdRdReq), 1);
        DcdFlash = 1'b1; req(3'd6, 2'b01, 32'h500);
        #1 chk("fl_success", 32'(DcdToLbSuccess), 0);
        chk("fl_rdreq", 32'(DcdRdReq), 0);
        cyc(); DcdFlash = 1'b0; req(3'd1, 2'b01, 32'h600);
        #1 chk("fl_mask_clear", 32'(DcdToLbSuccess), 1);
        chk("fl_queue_empty", 32'(DcdRdReq), 0);
        cyc(); LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        #1 chk_rd("fl_new", 32'h600, 1'b0);
        cyc(); MemRdReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drop(32'hBAD0_0000 + i);
            cyc();
        end
        ret(3'd1, 32'h6666_0001);
        cyc(); MemRdValid = 1'b0;
        cyc(2);

        req(3'd3, 2'b01, 32'h700); cyc();
        req(3'd4, 2'b01, 32'h704); cyc();
        LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        cyc(2); MemRdReady = 1'b0;
        DcdFlash = 1'b1; drop(32'hBAD1_0000);
        cyc(); DcdFlash = 1'b0; drop(32'hBAD1_0001);
        cyc(); MemRdValid = 1'b0; req(3'd5, 2'b01, 32'h800);
        #1 chk("fl2_accept", 32'(DcdToLbSuccess), 1);
        cyc(); LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        #1 chk_rd("fl2_new", 32'h800, 1'b0);
        cyc(); MemRdReady = 1'b0;
        ret(3'd5, 32'h5555_0005);
        cyc(); MemRdValid = 1'b0;
        cyc(2);

        req(3'd6, 2'b00, 32'h2000_0010);
        cyc(); LbToDcdAble = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk_rd("unc_stall", 32'h2000_0010, 1'b1);
            cyc();
        end
        MemRdReady = 1'b1;
        #1 chk_rd("unc_go", 32'h2000_0010, 1'b1);
        cyc(); MemRdReady = 1'b0;
        #1 chk("unc_done", 32'(DcdRdReq), 0);
        ret(3'd6, 32'h6060_6060);
        cyc(); MemRdValid = 1'b0;
        cyc(2);

        req(3'd1, 2'b01, 32'h900); cyc();
        req(3'd2, 2'b01, 32'h904); cyc();
        req(3'd3, 2'b01, 32'h908); Rest = 1'b1;
        #1 chk("midrst_success", 32'(DcdToLbSuccess), 0);
        cyc();
        #1 chk("midrst_rdreq", 32'(DcdRdReq), 0);
        chk("midrst_back", 32'(DcdToLbBackAble), 0);
        chk("midrst_success_hi", 32'(DcdToLbSuccess), 0);
        cyc(); Rest = 1'b0; LbToDcdAble = 1'b0;
        #1 chk("midrst_empty", 32'(DcdRdReq), 0);
        cyc(); req(3'd1, 2'b11, 32'hA00);
        #1 chk("midrst_mask_clear", 32'(DcdToLbSuccess), 1);
        cyc(); LbToDcdAble = 1'b0; MemRdReady = 1'b1;
        #1 chk_rd("midrst_new", 32'hA00, 1'b1);
        cyc(); MemRdReady = 1'b0;
        ret(3'd1, 32'hA0A0_A0A0);
        cyc(); MemRdValid = 1'b0;
        cyc(3);

        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
